wb_sequencer: RTL
=================

WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001: Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003: rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004: wb_valid_i  input  1  write-back stage offers one completed instruction.
REQ-005: wb_ready_o  output  1  sequencer accepts the offered instruction this cycle.
REQ-006: icode_i  input  4  instruction code of the offered instruction.
REQ-007: dstE_i / dstM_i  input  4 each  destination registers; 4'hF (RNONE) means no write.
REQ-008: valE_i / valM_i  input  64 each  write data for dstE / dstM.
REQ-009: stat_i  input  2  instruction status: 00 AOK, 01 HLT, 10 ADR, 11 INS.
REQ-010: rf_we_o  output  1  register-file write enable (single write port).
REQ-011: rf_waddr_o  output  4  register-file write address.
REQ-012: rf_wdata_o  output  64  register-file write data.
REQ-013: stat_o  output  2  processor status (latched).
REQ-014: halted_o  output  1  processor stopped; no further instructions accepted.
REQ-015: retired_o  output  CNT_W  count of retired AOK instructions.

Function
REQ-016: Handshake: accept occurs on a rising edge where wb_valid_i=1 and wb_ready_o=1; inputs are captured into holding registers on accept.
REQ-017: FSM states IDLE, WR_E, WR_M, HALT; state register, holding registers and counter are flops; rf_* outputs are decoded from state and holding registers only, never combinationally from inputs.
REQ-018: Write set of an accepted AOK instruction: needE = (dstE != F) and (dstE != dstM or dstM == F); needM = (dstM != F).
REQ-019: dstE == dstM != F: only the M write occurs (valM wins), in one cycle.
REQ-020: IDLE -> WR_E on accept of AOK with needE; -> WR_M on accept of AOK with !needE and needM; stays IDLE on accept of AOK with no writes; -> HALT on accept of any non-AOK stat_i.
REQ-021: WR_E: rf_we_o=1, rf_waddr_o=dstE, rf_wdata_o=valE; next WR_M if needM, else behaves as IDLE for a new accept.
REQ-022: WR_M: rf_we_o=1, rf_waddr_o=dstM, rf_wdata_o=valM; next behaves as IDLE for a new accept.
REQ-023: wb_ready_o = IDLE, or WR_E with !needM, or WR_M; 0 in WR_E with needM and in HALT.
REQ-024: Throughput: one instruction per cycle when each has at most one write; two-write instructions stall input for exactly one cycle.
REQ-025: Write latency: first write asserted in the cycle after accept; E write always precedes M write.
REQ-026: Non-AOK instruction performs no register writes; stat_o latches stat_i and halted_o=1 from the cycle after accept.
REQ-027: HALT is terminal: rf_we_o=0, wb_ready_o=0, stat_o and retired_o frozen until reset.
REQ-028: retired_o increments by 1 on each accept with stat_i=AOK; saturates at all-ones, no wrap.
REQ-029: Outside WR_E/WR_M, rf_we_o=0; rf_waddr_o and rf_wdata_o are 0.
REQ-030: icode_i is captured but does not alter sequencing; illegal codes arrive flagged through stat_i=INS.

Reset
REQ-031: rst_n_i low asynchronously forces state IDLE, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, stat_o=00, halted_o=0, retired_o=0, holding registers 0.
REQ-032: Reset asserted mid-write (WR_E or WR_M) aborts the pending write immediately; no M write follows release.
REQ-033: wb_ready_o=1 in the first cycle after reset release.

Verification
REQ-034: irmovq dstE=3 valE=0x1234 dstM=F AOK -> next cycle rf_we_o=1 waddr=3 wdata=0x1234; ready stays 1; retired_o=1.
REQ-035: mrmovq-like dstE=4 valE=0xA dstM=5 valM=0xB back-to-back with another valid -> writes (4,0xA) then (5,0xB) on consecutive cycles; ready low one cycle; second instruction accepted in WR_M cycle.
REQ-036: dstE=dstM=4 valE=0x1 valM=0x2 -> single write (4,0x2); no write of 0x1.
REQ-037: stat_i=10 (ADR) dstE=2 -> no write; stat_o=10, halted_o=1, ready=0 and all later valids ignored; stat_i=11 on a fresh run -> stat_o=11.
REQ-038: CNT_W=4, 16 AOK no-write instructions -> retired_o reaches 15 and holds.
REQ-039: rst_n_i pulsed low during WR_E of a two-write instruction -> outputs zero immediately; no write after release; ready=1.

Source files
------------

// File: rtl/wb_sequencer.sv
// Write-back sequencer: accepts completed instructions and serialises their
// E/M results onto a single register-file write port, latching halt status.
module wb_sequencer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wb_valid_i,
    output logic             wb_ready_o,
    input  logic [3:0]       icode_i,
    input  logic [3:0]       dstE_i,
    input  logic [3:0]       dstM_i,
    input  logic [63:0]      valE_i,
    input  logic [63:0]      valM_i,
    input  logic [1:0]       stat_i,
    output logic             rf_we_o,
    output logic [3:0]       rf_waddr_o,
    output logic [63:0]      rf_wdata_o,
    output logic [1:0]       stat_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_E = 2'd1,
        WR_M = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [1:0] AOK   = 2'b00;

    state_t      state;
    logic [3:0]  dst_m_h;
    logic [63:0] val_m_h;
    logic        need_m_h;
    logic [3:0]  icode_h;

    logic        accept;
    logic        need_e;
    logic        need_m;
    logic        unused_icode;

    // A same-register E/M pair collapses to the M write alone.
    assign need_m = (dstM_i != RNONE);
    assign need_e = (dstE_i != RNONE) && ((dstE_i != dstM_i) || !need_m);

    assign wb_ready_o = (state == IDLE) || (state == WR_M) ||
                        ((state == WR_E) && !need_m_h);
    assign accept     = wb_valid_i && wb_ready_o;
    assign halted_o   = (state == HALT);

    // icode is held for observability only; sequencing ignores it.
    assign unused_icode = ^icode_h;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            dst_m_h    <= '0;
            val_m_h    <= '0;
            need_m_h   <= 1'b0;
            icode_h    <= '0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            stat_o     <= AOK;
            retired_o  <= '0;
        end else begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            if (accept) begin
                dst_m_h  <= dstM_i;
                val_m_h  <= valM_i;
                need_m_h <= need_m;
                icode_h  <= icode_i;
                if (stat_i != AOK) begin
                    state  <= HALT;
                    stat_o <= stat_i;
                end else begin
                    if (retired_o != '1)
                        retired_o <= retired_o + CNT_W'(1);
                    if (need_e) begin
                        state      <= WR_E;
                        rf_we_o    <= 1'b1;
                        rf_waddr_o <= dstE_i;
                        rf_wdata_o <= valE_i;
                    end else if (need_m) begin
                        state      <= WR_M;
                        rf_we_o    <= 1'b1;
                        rf_waddr_o <= dstM_i;
                        rf_wdata_o <= valM_i;
                    end else begin
                        state <= IDLE;
                    end
                end
            end else begin
                case (state)
                    WR_E: begin
                        if (need_m_h) begin
                            state      <= WR_M;
                            rf_we_o    <= 1'b1;
                            rf_waddr_o <= dst_m_h;
                            rf_wdata_o <= val_m_h;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    HALT:    state <= HALT;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
